sd_multi_sec_test: RTL
======================

Name: sd_multi_sec_test

Overview:
Parametrised successor to the single-sector SD test-data generator. It writes a configurable run of consecutive sectors through the sd_ctrl_top user write port, reads them back through the read port, and checks every word. The data is either an incrementing pattern or an LFSR pattern. It sits between sd_ctrl_top and led_alarm, and adds mismatch counting, short-sector detection and busy timeouts.

Parameters:
DATA_W, 16, user data word width; must match sd_ctrl_top
SEC_NUM, 4, number of consecutive sectors per run (1..256)
START_ADDR, 32'd2000, first sector address
WORDS_PER_SEC, 256, words per sector (512 bytes / (DATA_W/8))
PATTERN, 0, 0 = incrementing, 1 = 16-bit LFSR
SEED, 16'hACE1, LFSR seed (must be nonzero)
TIMEOUT, 24'd10_000_000, clk cycles allowed per busy-rise or busy-fall wait
AUTO_START, 1, 1 = start a run on the rising edge of sd_init_done

Ports:
clk  in  1  system clock (clk_ref domain)
rst  in  1  synchronous reset, active-high
sd_init_done  in  1  card initialised
start  in  1  one-cycle pulse that starts a run (ignored while busy)
wr_busy  in  1  controller write busy
wr_req  in  1  controller samples wr_data this cycle
wr_start_en  out  1  one-cycle write start pulse
wr_sec_addr  out  32  write sector address
wr_data  out  DATA_W  write data
rd_busy  in  1  controller read busy
rd_val_en  in  1  rd_val_data valid
rd_val_data  in  DATA_W  read data
rd_start_en  out  1  one-cycle read start pulse
rd_sec_addr  out  32  read sector address
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
pass  out  1  level: last run had zero errors
error_flag  out  1  level: last run failed (drives led_alarm)
err_cnt  out  16  mismatch count, saturating at 16'hFFFF
timeout_err  out  1  level: a busy wait expired

Behaviour:
- Reset: all outputs 0, wr_sec_addr and rd_sec_addr = START_ADDR, FSM in IDLE.
- Start condition, from IDLE only: a start pulse, or (AUTO_START and sd_init_done 0→1). A start with sd_init_done=0 moves to WAIT_INIT.
- On start: clear err_cnt, pass, error_flag and timeout_err; set sector index s=0; busy=1.
- FSM states: IDLE, WAIT_INIT, WR_GO, WR_RISE, WR_FALL, RD_GO, RD_RISE, RD_FALL, CHECK, FINISH.
- WR_GO: wr_sec_addr=START_ADDR+s; wr_start_en high for exactly 1 cycle; word index k=0; go to WR_RISE.
- WR_RISE → WR_FALL when wr_busy=1.
- WR_FALL: when wr_busy=0, s++. If s==SEC_NUM, set s=0 and go to RD_GO; otherwise go to WR_GO.
- Write data: wr_data always presents pattern(s,k). The controller samples it on any cycle with wr_req=1; on that same edge k++ and wr_data updates to the next word. Word 0 is valid from WR_GO onward.
- RD_GO: rd_sec_addr=START_ADDR+s; rd_start_en high for 1 cycle; k=0. RD_RISE and RD_FALL mirror the write side using rd_busy.
- Read check: each rd_val_en cycle compares rd_val_data with pattern(s,k); on mismatch err_cnt++ (saturating); k++. Words beyond WORDS_PER_SEC are still compared with the continued pattern.
- CHECK (entered on the rd_busy fall): if k != WORDS_PER_SEC, err_cnt++ (short or long sector). Then s++; if s==SEC_NUM go to FINISH, else go to RD_GO.
- Timeout: a counter resets on every state entry. If it reaches TIMEOUT in any RISE or FALL state: timeout_err=1, go to FINISH.
- FINISH: pass=(err_cnt==0 && !timeout_err); error_flag=!pass; done pulse for 1 cycle; busy=0; go to IDLE. Results hold until the next start.
- Pattern 0: value = (s*WORDS_PER_SEC + k) truncated to DATA_W.
- Pattern 1: Galois LFSR x^16+x^14+x^13+x^11+1, reloaded at each sector start with SEED^s (if that is 0, use SEED instead). It steps once per consumed or checked word and is zero-extended or truncated to DATA_W.
- Generator and checker reload identically, so the expected data is reproducible.
- If wr_req or rd_val_en arrives outside its own phase it is ignored; no counter changes.
- rst asserted mid-run aborts immediately to the reset state; no done pulse is produced.
- A start pulse while busy=1 is ignored.

Test Plan:
- PATTERN=0, SEC_NUM=4, ideal controller model → 4 writes at addresses 2000..2003, then 4 reads; words 0..1023 correct; done after the last CHECK; pass=1, err_cnt=0.
- PATTERN=1, SEC_NUM=2, model corrupts read word 5 of sector 1 (XOR 16'h0001) → err_cnt=1, pass=0, error_flag=1.
- Model returns 255 words for sector 0 → err_cnt=1 (short sector), pass=0.
- Model never raises wr_busy, TIMEOUT=100 → timeout_err=1 at cycle 100 after WR_RISE entry, done pulse, error_flag=1.
- start pulse while busy plus rst asserted mid-read → second start ignored; after reset all outputs 0 and no done pulse.
- AUTO_START=1, sd_init_done rises at cycle 50 → wr_start_en pulses within 2 cycles; wr_sec_addr=2000.

Source files
------------

// File: rtl/sd_multi_sec_test.sv
`default_nettype none
//==============================================================================
// Module   : sd_multi_sec_test
// Purpose  : Multi-sector SD card self test. The block writes SEC_NUM
//            consecutive sectors starting at START_ADDR through the
//            sd_ctrl_top user write port. It then reads them back through the
//            read port and checks every word. The test data is either an
//            incrementing count or a 16-bit Galois LFSR. Outputs are
//            mismatch count, pass/fail levels and busy-wait timeout.
// Ports    : clk, rst                   - clock, synchronous active-high reset
//            sd_init_done, start        - run triggers
//            wr_busy, wr_req            - controller write handshake (in)
//            wr_start_en, wr_sec_addr,
//            wr_data                    - write request and data (out)
//            rd_busy, rd_val_en,
//            rd_val_data                - controller read handshake (in)
//            rd_start_en, rd_sec_addr   - read request (out)
//            busy, done, pass,
//            error_flag, err_cnt,
//            timeout_err                - run status and results (out)
// Revision : 1.0 - initial release
//==============================================================================
module sd_multi_sec_test #(
   parameter int          DATA_W        = 16,
   parameter int          SEC_NUM       = 4,
   parameter logic [31:0] START_ADDR    = 32'd2000,
   parameter int          WORDS_PER_SEC = 256,
   parameter int          PATTERN       = 0,
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter logic [23:0] TIMEOUT       = 24'd10_000_000,
   parameter bit          AUTO_START    = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sd_init_done,
   input  logic              start,
   input  logic              wr_busy,
   input  logic              wr_req,
   output logic              wr_start_en,
   output logic [31:0]       wr_sec_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              rd_busy,
   input  logic              rd_val_en,
   input  logic [DATA_W-1:0] rd_val_data,
   output logic              rd_start_en,
   output logic [31:0]       rd_sec_addr,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              error_flag,
   output logic [15:0]       err_cnt,
   output logic              timeout_err
);

   // The generator is at least 16 bits wide so that the LFSR always has room.
   localparam int          c_pat_w     = (DATA_W > 16) ? DATA_W : 16;
   localparam logic [15:0] c_lfsr_taps = 16'hB400;  // x^16+x^14+x^13+x^11+1
   localparam logic [8:0]  c_sec_num   = 9'(SEC_NUM);
   localparam logic [31:0] c_wps       = 32'(WORDS_PER_SEC);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_WAIT_INIT = 4'd1,
      S_WR_GO     = 4'd2,
      S_WR_RISE   = 4'd3,
      S_WR_FALL   = 4'd4,
      S_RD_GO     = 4'd5,
      S_RD_RISE   = 4'd6,
      S_RD_FALL   = 4'd7,
      S_CHECK     = 4'd8,
      S_FINISH    = 4'd9
   } state_t;

   state_t              r_state;
   logic [8:0]          r_sec;      // sector index within the run
   logic [31:0]         r_k;        // word index within the sector
   logic [c_pat_w-1:0]  r_pat;      // pattern word for (r_sec, r_k)
   logic [23:0]         r_tmo;
   logic                r_init_d;

   logic                w_start;
   logic                w_wr_phase;
   logic                w_rd_phase;
   logic [8:0]          w_sec_nxt;
   logic                w_last_sec;
   logic                w_tmo_hit;
   logic                w_clean;

   // First word of a sector: s*WORDS_PER_SEC for the count, SEED^s for the LFSR.
   function automatic logic [c_pat_w-1:0] pat_first(input logic [8:0] sec);
      logic [31:0] base;
      logic [15:0] seed;
      base = 32'(sec) * c_wps;
      seed = SEED ^ {7'd0, sec};
      if (seed == 16'd0) seed = SEED;
      if (PATTERN == 0) pat_first = c_pat_w'(base);
      else              pat_first = c_pat_w'(seed);
   endfunction

   // Word following v. The count keeps its upper bits; truncation at the output port takes care of them.
   function automatic logic [c_pat_w-1:0] pat_next(input logic [c_pat_w-1:0] v);
      logic [15:0] l;
      l = v[15:0];
      l = l[0] ? ((l >> 1) ^ c_lfsr_taps) : (l >> 1);
      if (PATTERN == 0) pat_next = v + c_pat_w'(1);
      else              pat_next = c_pat_w'(l);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign w_start    = start | (AUTO_START & sd_init_done & ~r_init_d);
   assign w_wr_phase = (r_state == S_WR_RISE) || (r_state == S_WR_FALL);
   assign w_rd_phase = (r_state == S_RD_RISE) || (r_state == S_RD_FALL);
   assign w_sec_nxt  = r_sec + 9'd1;
   assign w_last_sec = (w_sec_nxt == c_sec_num);
   assign w_tmo_hit  = (r_tmo == TIMEOUT - 24'd1);
   assign w_clean    = (err_cnt == 16'd0) && !timeout_err;
   assign wr_data    = r_pat[DATA_W-1:0];

   always_ff @(posedge clk) begin
      // Edge detector for sd_init_done. It keeps sampling during reset, so
      // releasing rst with the card already up does not look like a new rise.
      r_init_d <= sd_init_done;
      if (rst) begin
         r_state     <= S_IDLE;
         r_sec       <= 9'd0;
         r_k         <= 32'd0;
         r_pat       <= '0;
         r_tmo       <= 24'd0;
         wr_start_en <= 1'b0;
         rd_start_en <= 1'b0;
         wr_sec_addr <= START_ADDR;
         rd_sec_addr <= START_ADDR;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         error_flag  <= 1'b0;
         err_cnt     <= 16'd0;
         timeout_err <= 16'd0 == 16'd1;
      end else begin
         wr_start_en <= 1'b0;
         rd_start_en <= 1'b0;
         done        <= 1'b0;
         // Only the RISE/FALL states look at this counter. It is cleared on
         // the way into each of those states.
         r_tmo       <= r_tmo + 24'd1;

         // Word traffic is honoured only in its own phase. Everywhere else it is ignored.
         if (w_wr_phase && wr_req) begin
            r_k   <= r_k + 32'd1;
            r_pat <= pat_next(r_pat);
         end
         if (w_rd_phase && rd_val_en) begin
            r_k   <= r_k + 32'd1;
            r_pat <= pat_next(r_pat);
            if (rd_val_data != r_pat[DATA_W-1:0]) err_cnt <= sat_inc(err_cnt);
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  err_cnt     <= 16'd0;
                  pass        <= 1'b0;
                  error_flag  <= 1'b0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  r_sec       <= 9'd0;
                  if (sd_init_done) begin
                     r_pat   <= pat_first(9'd0);
                     r_k     <= 32'd0;
                     r_state <= S_WR_GO;
                  end else begin
                     r_state <= S_WAIT_INIT;
                  end
               end
            end
            S_WAIT_INIT: begin
               if (sd_init_done) begin
                  r_pat   <= pat_first(9'd0);
                  r_k     <= 32'd0;
                  r_state <= S_WR_GO;
               end
            end
            S_WR_GO: begin
               wr_sec_addr <= START_ADDR + 32'(r_sec);
               wr_start_en <= 1'b1;
               r_tmo       <= 24'd0;
               r_state     <= S_WR_RISE;
            end
            S_WR_RISE: begin
               if (wr_busy) begin
                  r_tmo   <= 24'd0;
                  r_state <= S_WR_FALL;
               end else if (w_tmo_hit) begin
                  timeout_err <= 1'b1;
                  r_state     <= S_FINISH;
               end
            end
            S_WR_FALL: begin
               // Loading the next sector here makes word 0 valid from the GO state onward.
               if (!wr_busy) begin
                  r_k <= 32'd0;
                  if (w_last_sec) begin
                     r_sec   <= 9'd0;
                     r_pat   <= pat_first(9'd0);
                     r_state <= S_RD_GO;
                  end else begin
                     r_sec   <= w_sec_nxt;
                     r_pat   <= pat_first(w_sec_nxt);
                     r_state <= S_WR_GO;
                  end
               end else if (w_tmo_hit) begin
                  timeout_err <= 1'b1;
                  r_state     <= S_FINISH;
               end
            end
            S_RD_GO: begin
               rd_sec_addr <= START_ADDR + 32'(r_sec);
               rd_start_en <= 1'b1;
               r_tmo       <= 24'd0;
               r_state     <= S_RD_RISE;
            end
            S_RD_RISE: begin
               if (rd_busy) begin
                  r_tmo   <= 24'd0;
                  r_state <= S_RD_FALL;
               end else if (w_tmo_hit) begin
                  timeout_err <= 1'b1;
                  r_state     <= S_FINISH;
               end
            end
            S_RD_FALL: begin
               if (!rd_busy) begin
                  r_state <= S_CHECK;
               end else if (w_tmo_hit) begin
                  timeout_err <= 1'b1;
                  r_state     <= S_FINISH;
               end
            end
            S_CHECK: begin
               // A sector of the wrong length counts as one extra error.
               if (r_k != c_wps) err_cnt <= sat_inc(err_cnt);
               if (w_last_sec) begin
                  r_state <= S_FINISH;
               end else begin
                  r_sec   <= w_sec_nxt;
                  r_pat   <= pat_first(w_sec_nxt);
                  r_k     <= 32'd0;
                  r_state <= S_RD_GO;
               end
            end
            S_FINISH: begin
               pass       <= w_clean;
               error_flag <= !w_clean;
               done       <= 1'b1;
               busy       <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
